// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Segment-register en/stall/flush and PC hold/redirect control for
//             a 5-stage pipeline (load-use, branch redirect, memory wait, halt)
//             with saturating performance counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             br_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_commit,
  output logic             pc_hold,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_lu;
  logic                 w_normal;
  logic [2:0]           w_cnt_inc;  // {freeze, flush, stall}
  logic [3*CNT_W-1:0]   w_cnt_q;

  assign w_lu = ex_is_load && (ex_rd != 5'd0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_normal    = 1'b0;
    w_cnt_inc   = 3'b000;
    pc_hold     = 1'b0;
    pc_redirect = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;

    case (r_state)
      RUN: begin
        if (halt_commit) begin
          mem_wb_en   = 1'b1;
          pc_hold     = 1'b1;
          w_state_nxt = HALTED;
        end else if (mem_req && !mem_ready) begin
          pc_hold      = 1'b1;
          w_cnt_inc[2] = 1'b1;
          w_state_nxt  = MEM_WAIT;
        end else begin
          w_normal = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_hold      = 1'b1;
          w_cnt_inc[2] = 1'b1;
        end else if (halt_commit) begin
          mem_wb_en   = 1'b1;
          pc_hold     = 1'b1;
          w_state_nxt = HALTED;
        end else begin
          w_normal    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      HALTED: begin
        pc_hold = 1'b1;
        halted  = 1'b1;
      end
      default: begin
        pc_hold     = 1'b1;
        w_state_nxt = RUN;
      end
    endcase

    // Branch squashes the ID instruction, so a coincident load-use is moot.
    if (w_normal) begin
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (br_redirect) begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_cnt_inc[1] = 1'b1;
      end else if (w_lu) begin
        pc_hold      = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
        w_cnt_inc[0] = 1'b1;
      end
    end

    if (rst) begin
      w_cnt_inc   = 3'b000;
      pc_hold     = 1'b1;
      pc_redirect = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_stall = 1'b0;
      id_ex_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_cnt_inc[gi] && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end

    assign w_cnt_q[gi*CNT_W +: CNT_W] = r_cnt;
  end

  assign stall_cnt  = w_cnt_q[0*CNT_W +: CNT_W];
  assign flush_cnt  = w_cnt_q[1*CNT_W +: CNT_W];
  assign freeze_cnt = w_cnt_q[2*CNT_W +: CNT_W];

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        br_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_commit;

  logic        pc_hold, pc_redirect, halted;
  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_stall, id_ex_stall, if_id_flush, id_ex_flush;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  logic        s_pc_hold, s_pc_redirect, s_halted;
  logic        s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_stall, s_id_ex_stall, s_if_id_flush, s_id_ex_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .br_redirect(br_redirect), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_commit(halt_commit), .pc_hold(pc_hold),
    .pc_redirect(pc_redirect), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .br_redirect(br_redirect), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_commit(halt_commit), .pc_hold(s_pc_hold),
    .pc_redirect(s_pc_redirect), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_stall(s_if_id_stall), .id_ex_stall(s_id_ex_stall),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .freeze_cnt(s_freeze_cnt)
  );

  wire [3:0] en_vec = {if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [3:0] sf_vec = {if_id_stall, id_ex_stall, if_id_flush, id_ex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    ex_is_load = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; br_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; halt_commit = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu_rs1();
    set_idle();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    br_redirect = 1'b1;
    halt_commit = 1'b1;
    #12;
    check_val("rst_en", {28'd0, en_vec}, 32'h0);
    check_val("rst_stall_flush", {28'd0, sf_vec}, 32'h0);
    check_val("rst_pc_hold", {31'd0, pc_hold}, 32'd1);
    check_val("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);
    set_idle();
    #5 rst = 1'b0;
    tick();

    // Idle RUN cycle
    #4;
    check_val("idle_en", {28'd0, en_vec}, 32'hF);
    check_val("idle_pc_hold", {31'd0, pc_hold}, 32'd0);
    tick();

    // Load-use on rs1
    set_lu_rs1();
    #4;
    check_val("lu_en", {28'd0, en_vec}, 32'hF);
    check_val("lu_pc_hold", {31'd0, pc_hold}, 32'd1);
    check_val("lu_stall_flush", {28'd0, sf_vec}, 32'b1001);
    tick();
    set_idle();
    check_val("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load to x0 is never a hazard
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #4;
    check_val("x0_stall_flush", {28'd0, sf_vec}, 32'b0000);
    check_val("x0_pc_hold", {31'd0, pc_hold}, 32'd0);
    tick();
    check_val("x0_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // rs2 matches but is unused: no hazard
    set_idle();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3;
    id_rs1_used = 1'b1;
    #4;
    check_val("rs2_unused", {28'd0, sf_vec}, 32'b0000);
    tick();
    // rs2 used and matching
    id_rs2_used = 1'b1;
    #4;
    check_val("rs2_lu", {28'd0, sf_vec}, 32'b1001);
    tick();
    set_idle();
    check_val("rs2_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Branch with simultaneous load-use: flush wins
    set_lu_rs1();
    br_redirect = 1'b1;
    #4;
    check_val("br_pc_redirect", {31'd0, pc_redirect}, 32'd1);
    check_val("br_stall_flush", {28'd0, sf_vec}, 32'b0011);
    check_val("br_pc_hold", {31'd0, pc_hold}, 32'd0);
    check_val("br_en", {28'd0, en_vec}, 32'hF);
    tick();
    set_idle();
    check_val("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    check_val("br_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Memory wait for 3 cycles then ready
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check_val($sformatf("mw_en_%0d", i), {28'd0, en_vec}, 32'h0);
      check_val($sformatf("mw_pc_hold_%0d", i), {31'd0, pc_hold}, 32'd1);
      tick();
    end
    check_val("mw_freeze_cnt", {16'd0, freeze_cnt}, 32'd3);
    mem_ready = 1'b1;
    #4;
    check_val("mw_ready_en", {28'd0, en_vec}, 32'hF);
    check_val("mw_ready_pc_hold", {31'd0, pc_hold}, 32'd0);
    tick();
    set_idle();
    #4;
    check_val("mw_back_run_en", {28'd0, en_vec}, 32'hF);
    check_val("mw_freeze_cnt2", {16'd0, freeze_cnt}, 32'd3);
    tick();

    // Freeze beats branch; branch is applied on the ready cycle
    mem_req = 1'b1; br_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #4;
      check_val($sformatf("mwb_redirect_%0d", i), {31'd0, pc_redirect}, 32'd0);
      check_val($sformatf("mwb_sf_%0d", i), {28'd0, sf_vec}, 32'b0000);
      tick();
    end
    mem_ready = 1'b1;
    #4;
    check_val("mwb_ready_redirect", {31'd0, pc_redirect}, 32'd1);
    check_val("mwb_ready_sf", {28'd0, sf_vec}, 32'b0011);
    tick();
    set_idle();
    check_val("mwb_freeze_cnt", {16'd0, freeze_cnt}, 32'd5);
    check_val("mwb_flush_cnt", {16'd0, flush_cnt}, 32'd2);

    // Halt
    halt_commit = 1'b1;
    br_redirect = 1'b1;
    #4;
    check_val("halt_en", {28'd0, en_vec}, 32'b0001);
    check_val("halt_redirect", {31'd0, pc_redirect}, 32'd0);
    tick();
    set_idle();
    br_redirect = 1'b1;
    set_lu_rs1();
    br_redirect = 1'b1;
    #4;
    check_val("halted_flag", {31'd0, halted}, 32'd1);
    check_val("halted_en", {28'd0, en_vec}, 32'h0);
    check_val("halted_pc_hold", {31'd0, pc_hold}, 32'd1);
    check_val("halted_redirect", {31'd0, pc_redirect}, 32'd0);
    tick();
    check_val("halted_sticky", {31'd0, halted}, 32'd1);
    check_val("halted_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    check_val("halted_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Asynchronous reset mid-cycle
    set_idle();
    #2 rst = 1'b1;
    #1;
    check_val("arst_halted", {31'd0, halted}, 32'd0);
    check_val("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check_val("arst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check_val("arst_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    #4;
    check_val("arst_run_en", {28'd0, en_vec}, 32'hF);
    tick();

    // Saturation: 2-bit counter vs 16-bit counter over 5 load-use cycles
    set_lu_rs1();
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_stall = (i > 3) ? 3 : i;
      check_val($sformatf("sat_cnt_%0d", i), {30'd0, s_stall_cnt}, exp_stall);
      check_val($sformatf("wide_cnt_%0d", i), {16'd0, stall_cnt}, i);
    end
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach the end, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Generates the en/stall/flush controls for the four pipeline segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold/redirect select.
- Resolves three conditions: load-use hazards, branch redirects from EX, and multi-cycle data-memory waits.
- Also handles halt on commit, and keeps saturating performance counters.
- Sits beside the datapath; it is the control end of the segment-register en/stall/flush interface.

Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the EX instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- br_redirect  in  1  EX resolved a taken/mispredicted branch
- mem_req  in  1  MEM stage has an active data access
- mem_ready  in  1  data memory completes the access this cycle
- halt_commit  in  1  halt instruction commits in WB
- pc_hold  out  1  PC register keeps its value
- pc_redirect  out  1  PC loads the EX branch target
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  segment enables
- if_id_stall, id_ex_stall  out  1 each  segment holds its value
- if_id_flush, id_ex_flush  out  1 each  segment loads a bubble
- halted  out  1  core stopped
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  perf counters

Behaviour:
- State machine:
  - States: RUN, MEM_WAIT, HALTED. Register state is async-reset to RUN.
  - Counters are async-reset to 0.
  - All control outputs are combinational from state and inputs.
- While rst is high:
  - All *_en = 0; all stall/flush = 0; pc_hold = 1; pc_redirect = 0; halted = 0; counters = 0.
- Load-use hazard definition:
  - lu = ex_is_load & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- RUN, priority highest first:
  1. halt_commit:
     - mem_wb_en = 1 this cycle so the halt retires; all other en = 0.
     - Next state HALTED.
  2. mem_req & !mem_ready (freeze):
     - All en = 0; pc_hold = 1; no flush.
     - Next state MEM_WAIT.
     - freeze_cnt += 1.
  3. br_redirect:
     - All en = 1; pc_redirect = 1; if_id_flush = 1; id_ex_flush = 1.
     - flush_cnt += 1.
     - A simultaneous lu is ignored, because the ID instruction is squashed.
  4. lu:
     - All en = 1; pc_hold = 1; if_id_stall = 1; id_ex_flush = 1 (one bubble).
     - stall_cnt += 1.
  5. Otherwise: all en = 1; all stall/flush/pc_hold/pc_redirect = 0.
- MEM_WAIT:
  - While !mem_ready: all en = 0; pc_hold = 1; freeze_cnt += 1.
  - EX, ID and IF are frozen, so br_redirect and lu stay stable and need no latching.
  - On mem_ready, in the same cycle:
    - Evaluate rules 3-5 exactly as in RUN.
    - halt_commit is also honoured with rule-1 behaviour.
    - Next state RUN, or HALTED if halt_commit.
- HALTED:
  - All en = 0; pc_hold = 1; halted = 1.
  - All other inputs are ignored; only rst exits this state.
- Flush and stall are never both asserted on the same segment. Flush takes precedence; this is enforced in the priority order above.
- Counters saturate at 2^CNT_W-1 and never wrap. Each increments at most once per cycle.
- Asserting rst mid-MEM_WAIT or in HALTED returns to RUN asynchronously; counters clear.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> pc_hold=1, if_id_stall=1, id_ex_flush=1, all en=1; stall_cnt 0->1.
- Load with rd=x0: ex_rd=0, id_rs1=0 -> no stall; stall_cnt stays 0.
- Branch + load-use in same cycle: br_redirect=1 with lu true -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all en=0 for 3 cycles; state MEM_WAIT; freeze_cnt=3; all en=1 on the ready cycle; state RUN next.
- Halt: halt_commit=1 -> only mem_wb_en=1 that cycle; next cycle halted=1, all en=0; br_redirect afterwards has no effect. Async rst pulse mid-cycle -> halted=0 and counters=0 immediately.
- Saturation with CNT_W=2: 5 consecutive lu cycles -> stall_cnt reads 1, 2, 3, 3, 3.
